eth_rx_block_lock: RTL

10GBASE-R receive block-lock engine (IEEE 802.3 clause 49.2.14 style) on the receive side of the 10G PHY. It consumes 2-bit sync headers from the GT RX gearbox, drives the gearbox slip request until header alignment is found, reports block lock, and counts bad headers. It sits between the GT RX gearbox outputs and the 64b/66b descrambler/decoder. The PHY's RX path gates decoded data on `rx_block_lock`.

---
 rtl/eth_phy_pkg.sv | 6 +
 rtl/eth_rx_block_lock.sv | 105 ++++++++++
 2 files changed

// File: rtl/eth_phy_pkg.sv
// eth_phy_pkg: shared 10GBASE-R PHY types and sync-header constants
package eth_phy_pkg;
  typedef enum logic [1:0] {HUNT, SLIP, WAIT, LOCKED} blk_state_e;
  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;
endpackage

// File: rtl/eth_rx_block_lock.sv
// eth_rx_block_lock: 64b/66b sync-header block lock with gearbox slip and bad-header count
module eth_rx_block_lock
  import eth_phy_pkg::*;
#(
  parameter int LOCK_COUNT    = 64,
  parameter int INVALID_LIMIT = 16,
  parameter int SLIP_WAIT     = 32,
  parameter int ERR_CNT_WIDTH = 7
) (
  input  logic                     rx_clk,
  input  logic                     rx_rst_n,
  input  logic [1:0]               serdes_rx_hdr,
  input  logic                     serdes_rx_hdr_valid,
  output logic                     serdes_rx_bitslip,
  output logic                     rx_block_lock,
  output logic [ERR_CNT_WIDTH-1:0] rx_bad_hdr_count,
  input  logic                     rx_bad_hdr_clear
);
  localparam int SHW = $clog2(LOCK_COUNT + 1);
  localparam int IVW = $clog2(INVALID_LIMIT + 1);
  localparam int WTW = $clog2(SLIP_WAIT + 1);

  blk_state_e               state_q, state_d;
  logic [SHW-1:0]           sh_cnt_q, sh_cnt_d, sh_inc;
  logic [IVW-1:0]           sh_invld_cnt_q, sh_invld_cnt_d, invld_inc;
  logic [WTW-1:0]           wait_cnt_q, wait_cnt_d;
  logic                     slip_q, slip_d, lock_q, lock_d;
  logic [ERR_CNT_WIDTH-1:0] bad_q, bad_d;
  logic                     hdr_bad, bad_inc;

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction

  // next-state, counter and registered-output logic
  always_comb begin
    hdr_bad        = !(serdes_rx_hdr == SYNC_DATA || serdes_rx_hdr == SYNC_CTRL);
    sh_inc         = sh_cnt_q + 1'b1;
    invld_inc      = sh_invld_cnt_q + IVW'(hdr_bad);
    state_d        = state_q;
    sh_cnt_d       = sh_cnt_q;
    sh_invld_cnt_d = sh_invld_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    case (state_q)
      HUNT: if (serdes_rx_hdr_valid) begin
        if (hdr_bad) state_d = SLIP;
        else if (sh_inc == SHW'(LOCK_COUNT)) begin
          state_d        = LOCKED;
          sh_cnt_d       = '0;
          sh_invld_cnt_d = '0;
        end else sh_cnt_d = sh_inc;
      end
      SLIP: begin
        state_d        = WAIT;
        wait_cnt_d     = WTW'(SLIP_WAIT);
        sh_cnt_d       = '0;
        sh_invld_cnt_d = '0;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - WTW'(wait_cnt_q != '0);
        state_d    = (wait_cnt_q <= WTW'(1)) ? HUNT : WAIT;
      end
      LOCKED: if (serdes_rx_hdr_valid) begin
        if (invld_inc == IVW'(INVALID_LIMIT)) state_d = SLIP;
        else if (sh_inc == SHW'(LOCK_COUNT)) begin
          sh_cnt_d       = '0;
          sh_invld_cnt_d = '0;
        end else begin
          sh_cnt_d       = sh_inc;
          sh_invld_cnt_d = invld_inc;
        end
      end
      default: state_d = HUNT;
    endcase
    slip_d  = state_d == SLIP;
    lock_d  = state_d == LOCKED;
    bad_inc = serdes_rx_hdr_valid && hdr_bad && state_q != WAIT;
    bad_d   = rx_bad_hdr_clear ? ERR_CNT_WIDTH'(bad_inc) : (bad_inc ? sat_inc(bad_q) : bad_q);
  end

  // state and output registers, cleared immediately by reset
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q        <= HUNT;
      sh_cnt_q       <= '0;
      sh_invld_cnt_q <= '0;
      wait_cnt_q     <= '0;
      slip_q         <= 1'b0;
      lock_q         <= 1'b0;
      bad_q          <= '0;
    end else begin
      state_q        <= state_d;
      sh_cnt_q       <= sh_cnt_d;
      sh_invld_cnt_q <= sh_invld_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      slip_q         <= slip_d;
      lock_q         <= lock_d;
      bad_q          <= bad_d;
    end
  end

  assign serdes_rx_bitslip = slip_q;
  assign rx_block_lock     = lock_q;
  assign rx_bad_hdr_count  = bad_q;
endmodule
